// File: rtl/rename_stage_pkg.sv
// Shared rename types: PRN/ARN/inst-id widths, architectural constants and the
// renamed-instruction record handed to the issue queue.
package rename_stage_pkg;

  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int ARN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int ARCH_REGS    = 32;
  localparam int ZERO_ARN     = 31;
  localparam int NUM_PRNS     = 1 << PRN_BITS;
  localparam int NUM_ARNS     = 1 << ARN_BITS;

  typedef logic [PRN_BITS-1:0]     prn_t;
  typedef logic [ARN_BITS-1:0]     arn_t;
  typedef logic [INST_ID_BITS-1:0] inst_id_t;
  typedef logic [PRN_BITS:0]       prn_cnt_t;
  typedef logic [MAX_OPERANDS-1:0] op_mask_t;

  typedef struct packed {
    inst_id_t                   inst_id;
    prn_t [MAX_OPERANDS-1:0]    src_prn;
    logic [MAX_OPERANDS-1:0]    dst_valid;
    prn_t [MAX_OPERANDS-1:0]    dst_prn;
  } renamed_inst_t;

  function automatic prn_cnt_t count_set(input op_mask_t m);
    prn_cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      c = c + prn_cnt_t'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// Circular PRN free list: up to MAX_OPERANDS pushes and pops per cycle, head entries
// readable combinationally; pops see only entries present at the start of the cycle.
module rename_stage_free_list
  import rename_stage_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [MAX_OPERANDS-1:0]                push_vld,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  push_prn,
  input  logic [PRN_BITS:0]                      pop_cnt,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  head_prn,
  output logic [PRN_BITS:0]                      count
);

  prn_t [NUM_PRNS-1:0] mem_q, mem_d;
  prn_t                head_q, head_d;
  prn_t                tail_q, tail_d;
  prn_cnt_t            count_q, count_d;
  prn_cnt_t            push_cnt;

  always_comb begin
    mem_d    = mem_q;
    tail_d   = tail_q;
    push_cnt = count_set(push_vld);
    // Valid pushes pack densely at the tail in operand order.
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (push_vld[i]) begin
        mem_d[tail_d] = push_prn[i];
        tail_d        = tail_d + prn_t'(1);
      end
    end
    head_d  = head_q + prn_t'(pop_cnt);
    count_d = count_q + push_cnt - pop_cnt;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      head_prn[k] = mem_q[head_q + prn_t'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRNS; i++) begin
        mem_q[i] <= (i < NUM_PRNS - ARCH_REGS) ? prn_t'(ARCH_REGS + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= prn_t'(NUM_PRNS - ARCH_REGS);
      count_q <= prn_cnt_t'(NUM_PRNS - ARCH_REGS);
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (int'(count_q) + int'(push_cnt) - int'(pop_cnt)) <= NUM_PRNS);

endmodule

// File: rtl/rename_stage.sv
// Register rename: map table + free list; rob_*/iq_* are combinational from in_* (0 cycles).
// in_ready drops when ROB or IQ back-pressure, a flush is active, or too few PRNs are free.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [63:0]                               in_pc,
  input  logic [MAX_OPERANDS-1:0]                   in_src_valid,
  input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]     in_src_arn,
  input  logic [MAX_OPERANDS-1:0]                   in_dst_valid,
  input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]     in_dst_arn,
  output logic                                      rob_inst_valid,
  input  logic                                      rob_inst_ready,
  output logic [63:0]                               rob_pc,
  output logic [MAX_OPERANDS-1:0]                   rob_mapping_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     rob_mapping_prn,
  output logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]     rob_mapping_arn,
  input  logic [INST_ID_BITS-1:0]                   rob_new_inst_id,
  output logic                                      iq_valid,
  input  logic                                      iq_ready,
  output logic [INST_ID_BITS-1:0]                   iq_inst_id,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     iq_src_prn,
  output logic [MAX_OPERANDS-1:0]                   iq_dst_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     iq_dst_prn,
  input  logic [MAX_OPERANDS-1:0]                   freed_prns_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     freed_prns,
  input  logic [MAX_OPERANDS-1:0]                   reset_valid,
  input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]     arn_reset,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     prn_reset,
  input  logic                                      stall_rename,
  output logic [PRN_BITS:0]                         free_count
);

  typedef logic [$clog2(MAX_OPERANDS+1)-1:0] slot_t;

  prn_t [NUM_ARNS-1:0]                     map_q, map_d;
  logic [MAX_OPERANDS-1:0]                 dst_cnt;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   head_prn;
  prn_cnt_t                                need, pop_cnt, free_cnt;
  logic                                    fire, dup_dst;
  slot_t                                   slot;
  renamed_inst_t                           iq_inst;

  rename_stage_free_list u_free_list (
    .clk      (clk),
    .rst      (rst),
    .push_vld (freed_prns_valid),
    .push_prn (freed_prns),
    .pop_cnt  (pop_cnt),
    .head_prn (head_prn),
    .count    (free_cnt)
  );

  always_comb begin
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      dst_cnt[i] = in_dst_valid[i] && (in_dst_arn[i] != arn_t'(ZERO_ARN));
    end
    need    = count_set(dst_cnt);
    dup_dst = 1'b0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      for (int j = i + 1; j < MAX_OPERANDS; j++) begin
        if (dst_cnt[i] && dst_cnt[j] && (in_dst_arn[i] == in_dst_arn[j])) dup_dst = 1'b1;
      end
    end

    in_ready = rob_inst_ready && iq_ready && !stall_rename && (free_cnt >= need);
    fire     = in_valid && in_ready;
    pop_cnt  = fire ? need : '0;

    // Sources and old mappings read the map before this instruction's writes.
    iq_inst           = '0;
    iq_inst.inst_id   = rob_new_inst_id;
    iq_inst.dst_valid = dst_cnt;
    slot              = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      iq_inst.src_prn[i]   = in_src_valid[i] ? map_q[in_src_arn[i]] : '0;
      rob_mapping_valid[i] = dst_cnt[i];
      rob_mapping_arn[i]   = in_dst_arn[i];
      rob_mapping_prn[i]   = map_q[in_dst_arn[i]];
      if (dst_cnt[i]) begin
        iq_inst.dst_prn[i] = head_prn[slot];
        slot               = slot + slot_t'(1);
      end
    end

    map_d = map_q;
    if (fire) begin
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        if (dst_cnt[i]) map_d[in_dst_arn[i]] = iq_inst.dst_prn[i];
      end
    end
    // Flush restores: later operand slots override earlier ones.
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (reset_valid[i]) map_d[arn_reset[i]] = prn_reset[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARNS; i++) begin
        map_q[i] <= (i < ARCH_REGS) ? prn_t'(i) : '0;
      end
    end else begin
      map_q <= map_d;
    end
  end

  assign rob_inst_valid = fire;
  assign iq_valid       = fire;
  assign rob_pc         = in_pc;
  assign iq_inst_id     = iq_inst.inst_id;
  assign iq_src_prn     = iq_inst.src_prn;
  assign iq_dst_valid   = iq_inst.dst_valid;
  assign iq_dst_prn     = iq_inst.dst_prn;
  assign free_count     = free_cnt;

  a_no_dup_dst: assert property (@(posedge clk) disable iff (rst) !(fire && dup_dst));
  a_no_fire_in_stall: assert property (@(posedge clk) disable iff (rst) !(fire && stall_rename));

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: a queue-based map/free-list model predicts each
// renamed instruction when it is driven; the prediction is popped when the DUT fires.
module tb_rename_stage;
  import rename_stage_pkg::*;

  logic clk, rst;
  logic in_valid, in_ready;
  logic [63:0] in_pc;
  logic [MAX_OPERANDS-1:0] in_src_valid, in_dst_valid;
  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] in_src_arn, in_dst_arn;
  logic rob_inst_valid, rob_inst_ready;
  logic [63:0] rob_pc;
  logic [MAX_OPERANDS-1:0] rob_mapping_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] rob_mapping_prn;
  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] rob_mapping_arn;
  logic [INST_ID_BITS-1:0] rob_new_inst_id, iq_inst_id;
  logic iq_valid, iq_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] iq_src_prn, iq_dst_prn;
  logic [MAX_OPERANDS-1:0] iq_dst_valid;
  logic [MAX_OPERANDS-1:0] freed_prns_valid, reset_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] freed_prns, prn_reset;
  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] arn_reset;
  logic stall_rename;
  logic [PRN_BITS:0] free_count;

  rename_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_src_valid(in_src_valid), .in_src_arn(in_src_arn),
    .in_dst_valid(in_dst_valid), .in_dst_arn(in_dst_arn),
    .rob_inst_valid(rob_inst_valid), .rob_inst_ready(rob_inst_ready), .rob_pc(rob_pc),
    .rob_mapping_valid(rob_mapping_valid), .rob_mapping_prn(rob_mapping_prn),
    .rob_mapping_arn(rob_mapping_arn), .rob_new_inst_id(rob_new_inst_id),
    .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_inst_id(iq_inst_id),
    .iq_src_prn(iq_src_prn), .iq_dst_valid(iq_dst_valid), .iq_dst_prn(iq_dst_prn),
    .freed_prns_valid(freed_prns_valid), .freed_prns(freed_prns),
    .reset_valid(reset_valid), .arn_reset(arn_reset), .prn_reset(prn_reset),
    .stall_rename(stall_rename), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]       pc;
    logic [5:0]        id;
    logic [2:0]        sv;
    logic [2:0]        dv;
    logic [2:0][5:0]   src;
    logic [2:0][5:0]   dst;
    logic [2:0][5:0]   mprn;
    logic [2:0][5:0]   marn;
  } exp_t;

  exp_t sb[$];
  int   mmap[NUM_ARNS];
  int   fq[$];
  int   tests_run, tests_failed;
  logic [63:0] pc_cnt;
  logic [5:0]  id_cnt;

  logic            obs_fire, obs_ready;
  logic [2:0]      obs_map_vld;
  logic [2:0][5:0] obs_src, obs_dst, obs_map_prn, obs_map_arn;
  logic [6:0]      obs_fc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_ARNS; i++) mmap[i] = (i < ARCH_REGS) ? i : 0;
    fq.delete();
    for (int p = ARCH_REGS; p < NUM_PRNS; p++) fq.push_back(p);
  endfunction

  function automatic void model_eval(output bit rdy, output exp_t e);
    int need, k;
    need = 0;
    e = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (in_dst_valid[i] && in_dst_arn[i] != 6'(ZERO_ARN)) begin
        e.dv[i] = 1'b1;
        need++;
      end
    end
    rdy  = rob_inst_ready && iq_ready && !stall_rename && (fq.size() >= need);
    e.pc = in_pc;
    e.id = rob_new_inst_id;
    e.sv = in_src_valid;
    k = 0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (in_src_valid[i]) e.src[i] = 6'(mmap[in_src_arn[i]]);
      if (e.dv[i]) begin
        e.marn[i] = in_dst_arn[i];
        e.mprn[i] = 6'(mmap[in_dst_arn[i]]);
        if (k < fq.size()) e.dst[i] = 6'(fq[k]);
        k++;
      end
    end
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_pc = '0;
    in_src_valid = '0; in_src_arn = '0; in_dst_valid = '0; in_dst_arn = '0;
    rob_inst_ready = 1; iq_ready = 1; rob_new_inst_id = '0;
    freed_prns_valid = '0; freed_prns = '0;
    reset_valid = '0; arn_reset = '0; prn_reset = '0;
    stall_rename = 0;
  endtask

  // Control inputs (ready/stall) must be set before calling, so the prediction sees them.
  task automatic drive_inst(input logic [2:0] sv, input logic [2:0][5:0] sa,
                            input logic [2:0] dv, input logic [2:0][5:0] da);
    bit   rdy;
    exp_t e;
    in_valid = 1; in_src_valid = sv; in_src_arn = sa; in_dst_valid = dv; in_dst_arn = da;
    in_pc = pc_cnt; rob_new_inst_id = id_cnt;
    pc_cnt = pc_cnt + 64'd4;
    id_cnt = id_cnt + 6'd1;
    model_eval(rdy, e);
    if (rdy) sb.push_back(e);
  endtask

  task automatic tick();
    bit   rdy;
    exp_t now_e, e;
    @(negedge clk);
    model_eval(rdy, now_e);
    obs_ready = in_ready; obs_fire = iq_valid; obs_src = iq_src_prn; obs_dst = iq_dst_prn;
    obs_map_vld = rob_mapping_valid; obs_map_prn = rob_mapping_prn;
    obs_map_arn = rob_mapping_arn; obs_fc = free_count;
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("free_count", 64'(free_count), 64'(fq.size()));
    check("rob_iq_valid", 64'(rob_inst_valid), 64'(iq_valid));
    if (iq_valid) begin
      check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rob_pc", rob_pc, e.pc);
        check("inst_id", 64'(iq_inst_id), 64'(e.id));
        check("dst_valid", 64'(iq_dst_valid), 64'(e.dv));
        check("map_valid", 64'(rob_mapping_valid), 64'(e.dv));
        for (int i = 0; i < MAX_OPERANDS; i++) begin
          if (e.sv[i]) check($sformatf("src_prn%0d", i), 64'(iq_src_prn[i]), 64'(e.src[i]));
          if (e.dv[i]) begin
            check($sformatf("dst_prn%0d", i), 64'(iq_dst_prn[i]), 64'(e.dst[i]));
            check($sformatf("map_prn%0d", i), 64'(rob_mapping_prn[i]), 64'(e.mprn[i]));
            check($sformatf("map_arn%0d", i), 64'(rob_mapping_arn[i]), 64'(e.marn[i]));
          end
        end
      end
    end
    if (in_valid && rdy) begin
      for (int i = 0; i < MAX_OPERANDS; i++) if (now_e.dv[i]) mmap[in_dst_arn[i]] = fq.pop_front();
    end
    for (int i = 0; i < MAX_OPERANDS; i++) if (reset_valid[i]) mmap[arn_reset[i]] = prn_reset[i];
    for (int i = 0; i < MAX_OPERANDS; i++) if (freed_prns_valid[i]) fq.push_back(freed_prns[i]);
    @(posedge clk);
    #1;
    in_valid = 0; freed_prns_valid = '0; reset_valid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    sb.delete();
    @(negedge clk);
    check("rst_free_count", 64'(free_count), 64'd32);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    pc_cnt = 64'h1000; id_cnt = '0;
    rst = 1;
    idle_inputs();

    // dst X1, srcs X2/X3 straight after reset
    do_reset();
    drive_inst(3'b011, {6'd0, 6'd3, 6'd2}, 3'b001, {6'd0, 6'd0, 6'd1});
    tick();
    check("t1_fire", 64'(obs_fire), 64'd1);
    check("t1_dst", 64'(obs_dst[0]), 64'd32);
    check("t1_src0", 64'(obs_src[0]), 64'd2);
    check("t1_src1", 64'(obs_src[1]), 64'd3);
    check("t1_map_vld", 64'(obs_map_vld), 64'b001);
    check("t1_map_arn", 64'(obs_map_arn[0]), 64'd1);
    check("t1_map_prn", 64'(obs_map_prn[0]), 64'd1);
    check("t1_fc_before", 64'(obs_fc), 64'd32);
    tick();
    check("t1_fc_after", 64'(obs_fc), 64'd31);

    // ROB and IQ back-pressure each block firing
    rob_inst_ready = 0;
    drive_inst(3'b001, {6'd0, 6'd0, 6'd1}, 3'b001, {6'd0, 6'd0, 6'd6});
    tick();
    check("bp_rob_fire", 64'(obs_fire), 64'd0);
    rob_inst_ready = 1; iq_ready = 0;
    drive_inst(3'b001, {6'd0, 6'd0, 6'd1}, 3'b001, {6'd0, 6'd0, 6'd6});
    tick();
    check("bp_iq_fire", 64'(obs_fire), 64'd0);
    iq_ready = 1;

    // back-to-back dependent renames
    do_reset();
    drive_inst(3'b001, {6'd0, 6'd0, 6'd1}, 3'b001, {6'd0, 6'd0, 6'd1});
    tick();
    check("t2a_src", 64'(obs_src[0]), 64'd1);
    check("t2a_dst", 64'(obs_dst[0]), 64'd32);
    drive_inst(3'b001, {6'd0, 6'd0, 6'd1}, 3'b001, {6'd0, 6'd0, 6'd2});
    tick();
    check("t2b_src", 64'(obs_src[0]), 64'd32);
    check("t2b_dst", 64'(obs_dst[0]), 64'd33);

    // exhaust the free list, then recycle PRN 5
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive_inst(3'b000, '0, 3'b001, {6'd0, 6'd0, 6'(i % 31)});
      tick();
    end
    drive_inst(3'b000, '0, 3'b001, {6'd0, 6'd0, 6'd7});
    freed_prns_valid = 3'b001; freed_prns = {6'd0, 6'd0, 6'd5};
    tick();
    check("t3_empty_ready", 64'(obs_ready), 64'd0);
    check("t3_empty_fc", 64'(obs_fc), 64'd0);
    drive_inst(3'b000, '0, 3'b001, {6'd0, 6'd0, 6'd7});
    tick();
    check("t3_recycled_ready", 64'(obs_ready), 64'd1);
    check("t3_recycled_dst", 64'(obs_dst[0]), 64'd5);

    // ZERO_ARN destination is not allocated
    do_reset();
    drive_inst(3'b000, '0, 3'b011, {6'd0, 6'd4, 6'd31});
    tick();
    check("t4_map_vld", 64'(obs_map_vld), 64'b010);
    check("t4_dst1", 64'(obs_dst[1]), 64'd32);
    check("t4_map_prn1", 64'(obs_map_prn[1]), 64'd4);
    tick();
    check("t4_fc_after", 64'(obs_fc), 64'd31);

    // flush restore under stall; higher restore slot wins
    do_reset();
    drive_inst(3'b000, '0, 3'b001, {6'd0, 6'd0, 6'd1});
    tick();
    stall_rename = 1;
    reset_valid = 3'b011; arn_reset = {6'd0, 6'd1, 6'd1}; prn_reset = {6'd0, 6'd1, 6'd7};
    drive_inst(3'b001, {6'd0, 6'd0, 6'd1}, 3'b001, {6'd0, 6'd0, 6'd5});
    tick();
    check("t5_stall_fire", 64'(obs_fire), 64'd0);
    check("t5_stall_ready", 64'(obs_ready), 64'd0);
    stall_rename = 0;
    drive_inst(3'b001, {6'd0, 6'd0, 6'd1}, 3'b001, {6'd0, 6'd0, 6'd5});
    tick();
    check("t5_restored_src", 64'(obs_src[0]), 64'd1);
    check("t5_dst", 64'(obs_dst[0]), 64'd33);

    // 3 pushes concurrent with a 2-destination fire at free_count=2
    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive_inst(3'b000, '0, 3'b001, {6'd0, 6'd0, 6'(i)});
      tick();
    end
    drive_inst(3'b000, '0, 3'b011, {6'd0, 6'd11, 6'd10});
    freed_prns_valid = 3'b111; freed_prns = {6'd5, 6'd4, 6'd3};
    tick();
    check("t6_fc_before", 64'(obs_fc), 64'd2);
    check("t6_dst0", 64'(obs_dst[0]), 64'd62);
    check("t6_dst1", 64'(obs_dst[1]), 64'd63);
    for (int i = 0; i < 3; i++) begin
      drive_inst(3'b000, '0, 3'b001, {6'd0, 6'd0, 6'(12 + i)});
      tick();
      if (i == 0) check("t6_fc_after", 64'(obs_fc), 64'd3);
      check($sformatf("t6_fifo%0d", i), 64'(obs_dst[0]), 64'(3 + i));
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register renamer between decode and the ROB/issue queues.
- Holds the speculative ARN->PRN map table and a circular free list of PRNs.
- Renames up to MAX_OPERANDS sources and MAX_OPERANDS destinations per instruction, one instruction per cycle.
- Sends the overwritten (old) mappings to the ROB, recycles PRNs the ROB frees at retire, and applies mapping restores during a ROB flush.

Parameters:
INST_ID_BITS, 6, ROB instruction-id width
PRN_BITS, 6, physical register number width (2^PRN_BITS PRNs)
MAX_OPERANDS, 3, max source / destination operands per instruction
ARCH_REGS, 32, architectural registers mapped at reset (ARNs 0..ARCH_REGS-1)
ZERO_ARN, 31, ARN whose writes are discarded (never allocated)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  rename can accept this cycle
in_pc  in  64  instruction PC
in_src_valid  in  1xMAX_OPERANDS  source operand present
in_src_arn  in  6xMAX_OPERANDS  source ARNs
in_dst_valid  in  1xMAX_OPERANDS  destination present
in_dst_arn  in  6xMAX_OPERANDS  destination ARNs (distinct within one instruction)
rob_inst_valid  out  1  dispatch to ROB
rob_inst_ready  in  1  ROB accepts
rob_pc  out  64  PC to ROB
rob_mapping_valid/prn/arn  out  1/PRN_BITS/6 xMAX_OPERANDS  old mapping overwritten per destination
rob_new_inst_id  in  INST_ID_BITS  id the ROB assigns
iq_valid  out  1  renamed instruction to issue
iq_ready  in  1  issue queue accepts
iq_inst_id  out  INST_ID_BITS  copy of rob_new_inst_id
iq_src_prn  out  PRN_BITS xMAX_OPERANDS  renamed sources
iq_dst_valid/iq_dst_prn  out  1/PRN_BITS xMAX_OPERANDS  newly allocated destinations
freed_prns_valid/freed_prns  in  1/PRN_BITS xMAX_OPERANDS  PRNs released by ROB retire
reset_valid/arn_reset/prn_reset  in  1/6/PRN_BITS xMAX_OPERANDS  flush restore writes
stall_rename  in  1  ROB flushing; no renaming allowed
free_count  out  PRN_BITS+1  PRNs currently free (debug/perf)

Behaviour:
- Reset:
  - map[i]=i for i<ARCH_REGS; other entries are don't-care.
  - Free list holds PRNs ARCH_REGS..2^PRN_BITS-1 in ascending order; head=0; free_count=2^PRN_BITS-ARCH_REGS.
  - Reset overrides all other inputs in the same cycle.
- need = number of i with in_dst_valid[i] && in_dst_arn[i]!=ZERO_ARN.
- Combinational path from in_* to rob_* and iq_* (0 cycles):
  - in_ready = rob_inst_ready && iq_ready && !stall_rename && free_count>=need.
  - rob_inst_valid = iq_valid = in_valid && in_ready.
  - fire = in_valid && in_ready.
- Source lookup reads the map before this instruction's writes: src==dst reads the old PRN. No same-cycle bypass from reset_* writes; stall_rename covers those cycles.
- Destination allocation:
  - The k-th counted destination (index order) takes free-list entry head+k.
  - rob_mapping_prn[i]=map[dst_arn[i]]; rob_mapping_arn[i]=dst_arn[i]; rob_mapping_valid[i]=counted.
  - ZERO_ARN or invalid destinations: valid=0, no PRN consumed.
- On fire (at clk edge): map[dst_arn]<=new PRN for each counted destination; head+=need.
- Free-list push: freed_prns_valid entries are appended at tail in index order every cycle, independent of fire.
- free_count' = free_count + pushes - (fire?need:0). Pops use only entries present at the start of the cycle (no push->pop bypass). Head and tail wrap modulo 2^PRN_BITS.
- Restore: each reset_valid[i] writes map[arn_reset[i]]<=prn_reset[i]. Within one cycle, index order applies and a higher index wins. Restore is never concurrent with fire, because stall_rename blocks fire.
- Flushed destination PRNs are not returned by this block; they return through ROB retire.
- Assertions:
  - push would make free_count exceed 2^PRN_BITS;
  - duplicate counted destination ARNs on fire;
  - fire while stall_rename.

Decomposition:
- Shared package holds: PRN/ARN/inst-id typedefs, ZERO_ARN, ARCH_REGS, and a renamed-instruction struct (inst_id, src_prn[], dst_valid[], dst_prn[]) used by the issue queue.
- One sub-module: free_list. It is a circular buffer with multi-push/multi-pop, count, and reset-time initial fill. The map table stays in rename_stage.

Test Plan:
- After reset, rename dst X1, srcs X2, X3 -> iq_dst_prn=32, rob_mapping {valid=1, arn=1, prn=1}, src PRNs 2, 3; free_count 32->31.
- Back-to-back: ADD X1<-X1 then X2<-X1 -> first src PRN 1, dst 32; second src PRN 32, dst 33.
- Exhaust the free list (32 renames), then an instruction needing 1 destination -> in_ready=0. Same cycle freed_prns_valid[0]=1, prn=5 -> in_ready=1 next cycle, allocates 5.
- Destination ZERO_ARN plus dst X4 -> only X4 allocated; rob_mapping_valid {0,1,0}; free_count drops by 1.
- stall_rename=1 with reset_valid arn=1 prn=1 after X1->32 -> no fire during stall; next rename reading X1 gets PRN 1.
- Simultaneous 3 pushes and a 2-destination fire at free_count=2 -> allocates the two old entries, free_count ends at 3; pushed PRNs appear in FIFO order afterwards.
